// File: rtl/fp_pkg.sv
// Shared FPU definitions: rounding-mode and converter state encodings,
// binary32/integer constants and the common rounding-increment decision.
package fp_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } r_mode_e;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ALIGN = 4'b0010,
        ST_ROUND = 4'b0100,
        ST_DONE  = 4'b1000
    } state_e;

    localparam int unsigned EXP_BIAS   = 127;
    localparam logic [7:0]  EXP_MAX    = 8'hFF;
    localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
    localparam logic [31:0] UINT32_MAX = 32'hFFFF_FFFF;

    // Reserved mode codes fall back to round-to-nearest-even.
    function automatic logic round_inc(input logic [2:0] mode, input logic sign,
                                       input logic lsb, input logic g, input logic s);
        case (mode)
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign & (g | s);
            RM_RUP:  return ~sign & (g | s);
            RM_RMM:  return g;
            default: return g & (s | lsb);
        endcase
    endfunction

endpackage

// File: rtl/fp32_unpack.sv
// Combinational binary32 field extraction and operand classification.
module fp32_unpack
    import fp_pkg::*;
(
    input  logic [31:0] fp_i,
    output logic        sign_o,
    output logic [7:0]  exp_o,
    output logic [23:0] mant_o,
    output logic        is_nan_o,
    output logic        is_inf_o,
    output logic        is_zero_o,
    output logic        is_subnormal_o
);

    logic frac_nz;

    always_comb begin
        sign_o         = fp_i[31];
        exp_o          = fp_i[30:23];
        frac_nz        = |fp_i[22:0];
        mant_o         = {|fp_i[30:23], fp_i[22:0]};
        is_nan_o       = (exp_o == EXP_MAX) && frac_nz;
        is_inf_o       = (exp_o == EXP_MAX) && !frac_nz;
        is_zero_o      = (exp_o == 8'h00) && !frac_nz;
        is_subnormal_o = (exp_o == 8'h00) && frac_nz;
    end

endmodule

// File: rtl/fp_to_int_converter.sv
// Iterative binary32 -> int32/uint32 converter with valid/ready on both sides.
// Define FP2INT_SVA_EN to compile in the embedded protocol/FSM assertions.
module fp_to_int_converter
    import fp_pkg::*;
#(
    parameter int unsigned SHIFT_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fp_in,
    input  logic [2:0]  r_mode,
    input  logic        is_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] int_out,
    output logic        invalid,
    output logic        inexact
);

    localparam logic [7:0] EXP_INT0   = 8'(EXP_BIAS + 23);
    localparam logic [4:0] SPC        = 5'(SHIFT_PER_CYCLE);
    localparam logic [4:0] MAX_RSHIFT = 5'd26;

    state_e      state_q;
    logic        out_valid_q, inv_q, inx_q;
    logic [31:0] int_q;
    logic        sign_q, signed_q, left_q, byp_q, g_q, s_q;
    logic [2:0]  mode_q;
    logic [31:0] mag_q;
    logic [4:0]  rem_q;

    logic        u_sign, u_nan, u_inf, u_zero, u_sub;
    logic [7:0]  u_exp;
    logic [23:0] u_mant;

    fp32_unpack u_unpack (
        .fp_i           (fp_in),
        .sign_o         (u_sign),
        .exp_o          (u_exp),
        .mant_o         (u_mant),
        .is_nan_o       (u_nan),
        .is_inf_o       (u_inf),
        .is_zero_o      (u_zero),
        .is_subnormal_o (u_sub)
    );

    logic [7:0]  e_eff;
    logic        left_d, oor, bypass, byp_inv;
    logic [4:0]  amt_d;
    logic [31:0] sat_pos, sat_neg, byp_int;

    always_comb begin
        e_eff   = u_sub ? 8'd1 : u_exp;
        left_d  = (u_exp >= EXP_INT0);
        if (left_d)
            amt_d = 5'(u_exp - EXP_INT0);
        else if ((EXP_INT0 - e_eff) > 8'(MAX_RSHIFT))
            amt_d = MAX_RSHIFT;
        else
            amt_d = 5'(EXP_INT0 - e_eff);
        oor     = is_signed ? ((u_exp >= 8'd158) && (fp_in != 32'hCF00_0000))
                            : (u_exp >= 8'd159);
        sat_pos = is_signed ? INT32_MAX : UINT32_MAX;
        sat_neg = is_signed ? INT32_MIN : 32'h0000_0000;
        bypass  = u_nan | u_inf | u_zero | oor;
        if (u_zero) begin
            byp_int = '0;
            byp_inv = 1'b0;
        end else if (u_nan) begin
            byp_int = sat_pos;
            byp_inv = 1'b1;
        end else begin
            byp_int = u_sign ? sat_neg : sat_pos;
            byp_inv = 1'b1;
        end
    end

    // One alignment step: up to SHIFT_PER_CYCLE single-bit shifts, guard/sticky trailing.
    logic [4:0]  step, rem_d;
    logic [31:0] mag_d;
    logic        g_d, s_d;

    always_comb begin
        step  = (rem_q < SPC) ? rem_q : SPC;
        rem_d = rem_q - step;
        mag_d = mag_q;
        g_d   = g_q;
        s_d   = s_q;
        for (int unsigned i = 0; i < SHIFT_PER_CYCLE; i++) begin
            if (5'(i) < step) begin
                if (left_q) begin
                    mag_d = {mag_d[30:0], 1'b0};
                end else begin
                    s_d   = s_d | g_d;
                    g_d   = mag_d[0];
                    mag_d = {1'b0, mag_d[31:1]};
                end
            end
        end
    end

    logic        inc;
    logic [32:0] sum;
    logic [31:0] res_int;
    logic        res_inv, res_inx;

    always_comb begin
        inc     = round_inc(mode_q, sign_q, mag_q[0], g_q, s_q);
        sum     = {1'b0, mag_q} + {32'h0, inc};
        res_int = sign_q ? (~sum[31:0] + 32'd1) : sum[31:0];
        res_inv = 1'b0;
        res_inx = g_q | s_q;
        if (signed_q) begin
            if (!sign_q && (sum > {1'b0, INT32_MAX})) begin
                res_int = INT32_MAX;
                res_inv = 1'b1;
            end else if (sign_q && (sum > {1'b0, INT32_MIN})) begin
                res_int = INT32_MIN;
                res_inv = 1'b1;
            end
        end else begin
            if (sum[32]) begin
                res_int = UINT32_MAX;
                res_inv = 1'b1;
            end else if (sign_q && (sum != '0)) begin
                res_int = '0;
                res_inv = 1'b1;
            end
        end
        if (res_inv)
            res_inx = 1'b0;
    end

    // Bypass results are written at accept; ROUND then only raises out_valid,
    // which keeps bypass latency at one cycle like an N=0 conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            int_q       <= '0;
            inv_q       <= 1'b0;
            inx_q       <= 1'b0;
            sign_q      <= 1'b0;
            signed_q    <= 1'b0;
            left_q      <= 1'b0;
            byp_q       <= 1'b0;
            g_q         <= 1'b0;
            s_q         <= 1'b0;
            mode_q      <= '0;
            mag_q       <= '0;
            rem_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        sign_q   <= u_sign;
                        signed_q <= is_signed;
                        mode_q   <= r_mode;
                        mag_q    <= {8'h00, u_mant};
                        g_q      <= 1'b0;
                        s_q      <= 1'b0;
                        left_q   <= left_d;
                        rem_q    <= amt_d;
                        byp_q    <= bypass;
                        int_q    <= byp_int;
                        inv_q    <= byp_inv;
                        inx_q    <= 1'b0;
                        state_q  <= (!bypass && (amt_d != '0)) ? ST_ALIGN : ST_ROUND;
                    end
                end
                ST_ALIGN: begin
                    mag_q <= mag_d;
                    g_q   <= g_d;
                    s_q   <= s_d;
                    rem_q <= rem_d;
                    if (rem_q <= SPC)
                        state_q <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (!byp_q) begin
                        int_q <= res_int;
                        inv_q <= res_inv;
                        inx_q <= res_inx;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign int_out   = int_q;
    assign invalid   = inv_q;
    assign inexact   = inx_q;

`ifdef FP2INT_SVA_EN
    localparam logic [4:0] MAX_ALIGN = 5'((26 + SHIFT_PER_CYCLE - 1) / SHIFT_PER_CYCLE);

    logic [4:0] align_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || (state_q != ST_ALIGN))
            align_cnt_q <= '0;
        else
            align_cnt_q <= align_cnt_q + 5'd1;
    end

    a_hold: assert property (@(posedge clk) disable iff (rst)
        out_valid && !out_ready |=> out_valid && $stable(int_out) && $stable(invalid) && $stable(inexact));
    a_ready_excl: assert property (@(posedge clk) disable iff (rst) in_ready |-> !out_valid);
    a_flag_excl: assert property (@(posedge clk) disable iff (rst) invalid |-> !inexact);
    a_align_bound: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_ALIGN) |-> (align_cnt_q < MAX_ALIGN));
    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(state_q));
`endif

endmodule

// File: tb/tb_fp_to_int_converter.sv
// Scoreboard bench: the driver queues hand-computed results, a monitor checks them.
module tb_fp_to_int_converter;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, is_signed, out_valid, out_ready, invalid, inexact;
    logic [31:0] fp_in, int_out;
    logic [2:0]  r_mode;

    always #5 clk = ~clk;

    fp_to_int_converter #(.SHIFT_PER_CYCLE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp_in     (fp_in),
        .r_mode    (r_mode),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .int_out   (int_out),
        .invalid   (invalid),
        .inexact   (inexact)
    );

    typedef struct {
        string       name;
        logic [31:0] v;
        logic        inv;
        logic        inx;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h with no pending vector", int_out);
                end else begin
                    check({sb[0].name, "_lat"}, 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                end
            end
            if (out_valid && out_ready && (sb.size() > 0)) begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_int"}, int_out, mon_e.v);
                check({mon_e.name, "_inv"}, {31'h0, invalid}, {31'h0, mon_e.inv});
                check({mon_e.name, "_inx"}, {31'h0, inexact}, {31'h0, mon_e.inx});
            end
            prev_v = out_valid;
        end
    end

    task automatic send(input string name, input logic [31:0] fp, input logic [2:0] m,
                        input logic sg, input logic [31:0] v, input logic inv,
                        input logic inx, input int lat);
        int   t;
        exp_t e;
        fp_in     = fp;
        r_mode    = m;
        is_signed = sg;
        in_valid  = 1'b1;
        t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_accept: in_ready stayed %b, expected 1", name, in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.name = name;
        e.v    = v;
        e.inv  = inv;
        e.inx  = inx;
        e.lat  = lat;
        e.acc  = cyc;
        sb.push_back(e);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input string name, input logic [31:0] fp, input logic [2:0] m,
                       input logic sg, input logic [31:0] v, input logic inv,
                       input logic inx, input int lat);
        send(name, fp, m, sg, v, inv, inx, lat);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst       = 1'b1;
        in_valid  = 1'b0;
        fp_in     = '0;
        r_mode    = '0;
        is_signed = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_int_out",   int_out, 32'h0);
        check("rst_invalid",   {31'h0, invalid}, 32'h0);
        check("rst_inexact",   {31'h0, inexact}, 32'h0);
        check("rst_in_ready",  {31'h0, in_ready}, 32'h1);

        run("p25_rne",  32'h4020_0000, 3'b000, 1'b1, 32'h0000_0002, 1'b0, 1'b1, 7);
        run("p25_rmm",  32'h4020_0000, 3'b100, 1'b1, 32'h0000_0003, 1'b0, 1'b1, 7);
        run("p25_rup",  32'h4020_0000, 3'b011, 1'b1, 32'h0000_0003, 1'b0, 1'b1, 7);
        run("p25_rtz",  32'h4020_0000, 3'b001, 1'b1, 32'h0000_0002, 1'b0, 1'b1, 7);
        run("p25_m7",   32'h4020_0000, 3'b111, 1'b1, 32'h0000_0002, 1'b0, 1'b1, 7);
        run("n25_rdn",  32'hC020_0000, 3'b010, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b1, 7);
        run("n25_rup",  32'hC020_0000, 3'b011, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1, 7);
        run("p15_rne",  32'h3FC0_0000, 3'b000, 1'b1, 32'h0000_0002, 1'b0, 1'b1, 7);
        run("p2e31_s",  32'h4F00_0000, 3'b000, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        run("n2e31_s",  32'hCF00_0000, 3'b000, 1'b1, 32'h8000_0000, 1'b0, 1'b0, 3);
        run("p2e31_u",  32'h4F00_0000, 3'b000, 1'b0, 32'h8000_0000, 1'b0, 1'b0, 3);
        run("p2e32_u",  32'h4F80_0000, 3'b000, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
        run("p2e30_s",  32'h4E80_0000, 3'b000, 1'b1, 32'h4000_0000, 1'b0, 1'b0, 3);
        run("qnan_s",   32'h7FC0_0000, 3'b000, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
        run("qnan_u",   32'h7FC0_0000, 3'b000, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
        run("ninf_u",   32'hFF80_0000, 3'b000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1);
        run("ninf_s",   32'hFF80_0000, 3'b000, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 1);
        run("zero",     32'h0000_0000, 3'b011, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1);
        run("n075_rtz", 32'hBF40_0000, 3'b001, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 7);
        run("n075_rne", 32'hBF40_0000, 3'b000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 7);
        run("one",      32'h3F80_0000, 3'b000, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 7);
        run("exp150",   32'h4B00_0001, 3'b000, 1'b0, 32'h0080_0001, 1'b0, 1'b0, 1);
        run("subn_rup", 32'h0000_0001, 3'b011, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 8);

        // Back-pressure: hold DONE for five cycles, then release.
        out_ready = 1'b0;
        send("bp", 32'h3FC0_0000, 3'b000, 1'b1, 32'h0000_0002, 1'b0, 1'b1, 7);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_valid", {31'h0, out_valid}, 32'h1);
            check("bp_hold_int",   int_out, 32'h0000_0002);
            check("bp_hold_inx",   {31'h0, inexact}, 32'h1);
            check("bp_in_ready",   {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_idle_ready", {31'h0, in_ready}, 32'h1);
        check("bp_idle_valid", {31'h0, out_valid}, 32'h0);
        drain();

        // Reset in the middle of ALIGN discards the conversion.
        fp_in     = 32'h3F80_0000;
        r_mode    = 3'b000;
        is_signed = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        check("mid_rst_ready", {31'h0, in_ready}, 32'h1);
        check("mid_rst_int",   int_out, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        run("post_rst", 32'h4020_0000, 3'b100, 1'b1, 32'h0000_0003, 1'b0, 1'b1, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
